mem_stage: RTL and testbench

//  Memory stage of the 5-stage RV32I pipeline. Consumes bus_stage_e from execute and produces bus_stage_m for writeback.

---
 rtl/utils_pkg.sv | 57 +++++
 rtl/mem_stage_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
`default_nettype none
// ============================================================================
// utils_pkg : shared RV32I pipeline buses plus memory-stage FSM and funct3 codes
// Revision  : 1.0
// ============================================================================
package utils_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MS_IDLE     = 2'd0,
    MS_REQ      = 2'd1,
    MS_WAIT_RSP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0] ex_out;
    logic [XLEN-1:0] rf_rdata2;
    logic [3:0]      dmem_wr_en;
    logic [1:0]      sel_res;
    logic [2:0]      funct3;
    logic            rf_wr_en;
    logic [4:0]      rd;
    logic [1:0]      sel_rf_wr;
    logic [XLEN-1:0] inc_pc;
    logic            ecall;
  } bus_stage_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            rf_wr_en;
    logic [4:0]      rd;
    logic [1:0]      sel_rf_wr;
    logic [XLEN-1:0] inc_pc;
    logic            ecall;
  } bus_stage_m;

  // Access size comes from funct3[1:0]; unknown load codes fall back to word size.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// mem_load_align : selects the addressed byte/half of a load word and extends it
// Revision       : 1.0
// ============================================================================
module mem_load_align
  import utils_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  assign w_half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   load_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  load_data = {24'd0, w_byte};
      F3_LHU:  load_data = {16'd0, w_half};
      default: load_data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : RV32I memory stage - data memory req/gnt/rvalid access and load/store alignment
// Revision  : 1.0
// ============================================================================
module mem_stage
  import utils_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            e_valid_i,
  input  bus_stage_e      e_bus_i,
  output logic            e_ready_o,
  output logic            m_valid_o,
  output bus_stage_m      m_bus_o,
  output logic            misaligned_o,
  output logic            dmem_req_o,
  output logic [3:0]      dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  mem_state_t      r_state,      w_state_nxt;
  logic            r_m_valid,    w_m_valid_nxt;
  logic            r_misaligned, w_misaligned_nxt;
  bus_stage_m      r_m_bus,      w_m_bus_nxt;
  logic            r_req,        w_req_nxt;
  logic [3:0]      r_we,         w_we_nxt;
  logic [XLEN-1:0] r_addr,       w_addr_nxt;
  logic [XLEN-1:0] r_wdata,      w_wdata_nxt;
  bus_stage_m      r_hold,       w_hold_nxt;
  logic [2:0]      r_hold_f3,    w_hold_f3_nxt;
  logic            r_hold_store, w_hold_store_nxt;

  logic            w_accept;
  logic            w_is_store;
  logic            w_is_load;
  logic            w_misaligned;
  bus_stage_m      w_pass;
  logic [XLEN-1:0] w_store_data;
  logic [XLEN-1:0] w_load_data;

  assign e_ready_o    = (r_state == MS_IDLE);
  assign w_accept     = e_valid_i & e_ready_o;
  assign w_is_store   = (e_bus_i.dmem_wr_en != 4'd0);
  assign w_is_load    = (e_bus_i.sel_res == 2'd1) && !w_is_store;
  assign w_misaligned = is_misaligned(e_bus_i.funct3, e_bus_i.ex_out[1:0]);

  always_comb begin
    w_pass.result    = e_bus_i.ex_out;
    w_pass.rf_wr_en  = e_bus_i.rf_wr_en;
    w_pass.rd        = e_bus_i.rd;
    w_pass.sel_rf_wr = e_bus_i.sel_rf_wr;
    w_pass.inc_pc    = e_bus_i.inc_pc;
    w_pass.ecall     = e_bus_i.ecall;
  end

  // Replicate the store operand so it lands on whichever lane the byte enables pick.
  always_comb begin
    case (e_bus_i.funct3)
      F3_SB:   w_store_data = {4{e_bus_i.rf_rdata2[7:0]}};
      F3_SH:   w_store_data = {2{e_bus_i.rf_rdata2[15:0]}};
      default: w_store_data = e_bus_i.rf_rdata2;
    endcase
  end

  mem_load_align u_load_align (
    .rdata     (dmem_rdata_i),
    .addr      (r_hold.result[1:0]),
    .funct3    (r_hold_f3),
    .load_data (w_load_data)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_m_valid_nxt    = 1'b0;
    w_misaligned_nxt = 1'b0;
    w_m_bus_nxt      = r_m_bus;
    w_req_nxt        = r_req;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_hold_nxt       = r_hold;
    w_hold_f3_nxt    = r_hold_f3;
    w_hold_store_nxt = r_hold_store;

    case (r_state)
      MS_IDLE: begin
        if (w_accept) begin
          if (!(w_is_store || w_is_load)) begin
            w_m_valid_nxt = 1'b1;
            w_m_bus_nxt   = w_pass;
          end else if (w_misaligned) begin
            w_m_valid_nxt        = 1'b1;
            w_misaligned_nxt     = 1'b1;
            w_m_bus_nxt          = w_pass;
            w_m_bus_nxt.rf_wr_en = 1'b0;
          end else begin
            w_state_nxt      = MS_REQ;
            w_req_nxt        = 1'b1;
            w_we_nxt         = w_is_store ? (e_bus_i.dmem_wr_en << e_bus_i.ex_out[1:0]) : 4'd0;
            w_addr_nxt       = {e_bus_i.ex_out[XLEN-1:2], 2'b00};
            w_wdata_nxt      = w_store_data;
            w_hold_nxt       = w_pass;
            w_hold_f3_nxt    = e_bus_i.funct3;
            w_hold_store_nxt = w_is_store;
          end
        end
      end

      MS_REQ: begin
        if (dmem_gnt_i) begin
          w_req_nxt = 1'b0;
          w_we_nxt  = 4'd0;
          if (r_hold_store) begin
            w_state_nxt   = MS_IDLE;
            w_m_valid_nxt = 1'b1;
            w_m_bus_nxt   = r_hold;
          end else begin
            w_state_nxt = MS_WAIT_RSP;
          end
        end
      end

      MS_WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          w_state_nxt        = MS_IDLE;
          w_m_valid_nxt      = 1'b1;
          w_m_bus_nxt        = r_hold;
          w_m_bus_nxt.result = w_load_data;
        end
      end

      default: w_state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= MS_IDLE;
      r_m_valid    <= 1'b0;
      r_misaligned <= 1'b0;
      r_m_bus      <= '0;
      r_req        <= 1'b0;
      r_we         <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hold       <= '0;
      r_hold_f3    <= 3'd0;
      r_hold_store <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_m_valid    <= w_m_valid_nxt;
      r_misaligned <= w_misaligned_nxt;
      r_m_bus      <= w_m_bus_nxt;
      r_req        <= w_req_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_f3    <= w_hold_f3_nxt;
      r_hold_store <= w_hold_store_nxt;
    end
  end

  assign m_valid_o    = r_m_valid;
  assign misaligned_o = r_misaligned;
  assign m_bus_o      = r_m_bus;
  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : directed + randomized self-checking bench for mem_stage
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;
  import utils_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        e_valid_i;
  bus_stage_e  e_bus_i;
  logic        e_ready_o;
  logic        m_valid_o;
  bus_stage_m  m_bus_o;
  logic        misaligned_o;
  logic        dmem_req_o;
  logic [3:0]  dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .e_valid_i     (e_valid_i),
    .e_bus_i       (e_bus_i),
    .e_ready_o     (e_ready_o),
    .m_valid_o     (m_valid_o),
    .m_bus_o       (m_bus_o),
    .misaligned_o  (misaligned_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    longint unsigned v;
    int n;
    n = acc_bytes(f3);
    v = (longint'(word) >> (8 * int'(off))) & ((64'd1 << (8 * n)) - 64'd1);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'd1 << (8 * n - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (acc_bytes(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_we(input logic [2:0] f3, input logic [31:0] addr);
    int en;
    en = ((1 << acc_bytes(f3)) - 1) << (addr % 4);
    return 32'(en & 15);
  endfunction

  // kind: 0 = non-mem, 1 = load, 2 = store
  function automatic bus_stage_e mk(input int kind, input logic [2:0] f3,
                                    input logic [31:0] ex, input logic [31:0] d);
    bus_stage_e b;
    b.ex_out     = ex;
    b.rf_rdata2  = d;
    b.funct3     = f3;
    b.rf_wr_en   = (kind != 2);
    b.rd         = 5'($urandom_range(1, 31));
    b.sel_rf_wr  = 2'($urandom_range(0, 3));
    b.inc_pc     = $urandom & 32'hFFFF_FFFC;
    b.ecall      = 1'b0;
    b.sel_res    = (kind == 1) ? 2'd1 : ((kind == 0) ? 2'd0 : 2'($urandom_range(0, 3)));
    b.dmem_wr_en = (kind == 2) ? 4'(((1 << acc_bytes(f3)) - 1)) : 4'd0;
    return b;
  endfunction

  // Issues one instruction from IDLE and follows it until its m_valid_o pulse.
  task automatic do_op(input string tag, input bus_stage_e b, input int gnt_dly,
                       input int rv_dly, input logic [31:0] rdata);
    bit is_st, is_ld, mis;
    logic [31:0] exp_we, exp_wd;
    is_st  = (b.dmem_wr_en != 4'd0);
    is_ld  = (b.sel_res == 2'd1) && !is_st;
    mis    = (is_st || is_ld) && ((b.ex_out % 32'(acc_bytes(b.funct3))) != 0);
    exp_we = is_st ? ref_we(b.funct3, b.ex_out) : 32'd0;
    exp_wd = ref_wdata(b.rf_rdata2, b.funct3);

    chk({tag, ".ready_in"}, 32'(e_ready_o), 32'd1);
    e_valid_i = 1'b1;
    e_bus_i   = b;
    tick();
    e_valid_i = 1'b0;
    e_bus_i   = '0;

    if (!(is_st || is_ld) || mis) begin
      chk({tag, ".mvalid"}, 32'(m_valid_o), 32'd1);
      chk({tag, ".misal"}, 32'(misaligned_o), 32'(mis));
      chk({tag, ".noreq"}, 32'(dmem_req_o), 32'd0);
      chk({tag, ".result"}, m_bus_o.result, b.ex_out);
      chk({tag, ".wren"}, 32'(m_bus_o.rf_wr_en), mis ? 32'd0 : 32'(b.rf_wr_en));
      chk({tag, ".rd"}, 32'(m_bus_o.rd), 32'(b.rd));
      return;
    end

    chk({tag, ".req"}, 32'(dmem_req_o), 32'd1);
    chk({tag, ".addr"}, dmem_addr_o, b.ex_out & 32'hFFFF_FFFC);
    chk({tag, ".we"}, 32'(dmem_we_o), exp_we);
    if (is_st) chk({tag, ".wdata"}, dmem_wdata_o, exp_wd);
    chk({tag, ".stall"}, 32'(e_ready_o), 32'd0);
    chk({tag, ".mv_req"}, 32'(m_valid_o), 32'd0);
    for (int i = 0; i < gnt_dly; i++) begin
      dmem_rvalid_i = 1'($urandom_range(0, 1));
      tick();
      chk({tag, ".req_hold"}, 32'(dmem_req_o), 32'd1);
      chk({tag, ".addr_hold"}, dmem_addr_o, b.ex_out & 32'hFFFF_FFFC);
      chk({tag, ".we_hold"}, 32'(dmem_we_o), exp_we);
      if (is_st) chk({tag, ".wd_hold"}, dmem_wdata_o, exp_wd);
      chk({tag, ".mv_hold"}, 32'(m_valid_o), 32'd0);
    end
    dmem_rvalid_i = 1'b0;
    dmem_gnt_i    = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk({tag, ".req_drop"}, 32'(dmem_req_o), 32'd0);

    if (is_st) begin
      chk({tag, ".mvalid"}, 32'(m_valid_o), 32'd1);
      chk({tag, ".result"}, m_bus_o.result, b.ex_out);
      chk({tag, ".ready_out"}, 32'(e_ready_o), 32'd1);
    end else begin
      chk({tag, ".mv_wait"}, 32'(m_valid_o), 32'd0);
      chk({tag, ".stall_wait"}, 32'(e_ready_o), 32'd0);
      for (int i = 0; i < rv_dly; i++) begin
        dmem_gnt_i = 1'($urandom_range(0, 1));
        tick();
        chk({tag, ".mv_wait"}, 32'(m_valid_o), 32'd0);
      end
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      tick();
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = $urandom;
      chk({tag, ".mvalid"}, 32'(m_valid_o), 32'd1);
      chk({tag, ".misal"}, 32'(misaligned_o), 32'd0);
      chk({tag, ".result"}, m_bus_o.result, ref_load(rdata, b.ex_out[1:0], b.funct3));
      chk({tag, ".wren"}, 32'(m_bus_o.rf_wr_en), 32'(b.rf_wr_en));
      chk({tag, ".rd"}, 32'(m_bus_o.rd), 32'(b.rd));
      chk({tag, ".incpc"}, m_bus_o.inc_pc, b.inc_pc);
    end
  endtask

  initial begin
    bus_stage_e b;
    logic [2:0] ld_f3 [8];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    rst_n         = 1'b0;
    e_valid_i     = 1'b0;
    e_bus_i       = '0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    tick();
    tick();
    chk("rst.ready", 32'(e_ready_o), 32'd1);
    chk("rst.mvalid", 32'(m_valid_o), 32'd0);
    chk("rst.misal", 32'(misaligned_o), 32'd0);
    chk("rst.req", 32'(dmem_req_o), 32'd0);
    chk("rst.we", 32'(dmem_we_o), 32'd0);
    chk("rst.addr", dmem_addr_o, 32'd0);
    chk("rst.wdata", dmem_wdata_o, 32'd0);
    chk("rst.result", m_bus_o.result, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: three back-to-back non-mem instructions
    e_valid_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      e_bus_i = mk(0, 3'd0, 32'(i), 32'd0);
      chk("t1.ready", 32'(e_ready_o), 32'd1);
      tick();
      chk("t1.mvalid", 32'(m_valid_o), 32'd1);
      chk("t1.result", m_bus_o.result, 32'(i));
    end
    e_valid_i = 1'b0;
    tick();
    chk("t1.mv_drop", 32'(m_valid_o), 32'd0);

    // 2: LB sign-extended, fastest handshake
    do_op("t2", mk(1, F3_LB, 32'h0000_1003, 32'd0), 0, 0, 32'h80FF_0000);
    chk("t2.abs_result", m_bus_o.result, 32'hFFFF_FF80);
    tick();

    // 3: SH with grant delayed four cycles
    b = mk(2, F3_SH, 32'h0000_2002, 32'h1234_ABCD);
    do_op("t3", b, 4, 0, 32'd0);
    tick();

    // 4: misaligned LW
    do_op("t4", mk(1, F3_LW, 32'h0000_3001, 32'd0), 0, 0, 32'd0);
    tick();
    chk("t4.mv_drop", 32'(m_valid_o), 32'd0);

    // 5: LHU with a following ADD held until the response arrives
    e_valid_i = 1'b1;
    e_bus_i   = mk(1, F3_LHU, 32'h0000_4002, 32'd0);
    tick();
    e_bus_i    = mk(0, 3'd0, 32'h0000_0055, 32'd0);
    dmem_gnt_i = 1'b1;
    chk("t5.req", 32'(dmem_req_o), 32'd1);
    chk("t5.ready_req", 32'(e_ready_o), 32'd0);
    tick();
    dmem_gnt_i = 1'b0;
    chk("t5.ready_wait", 32'(e_ready_o), 32'd0);
    tick();
    chk("t5.mv_wait", 32'(m_valid_o), 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hBEEF_0000;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("t5.ld_mvalid", 32'(m_valid_o), 32'd1);
    chk("t5.ld_result", m_bus_o.result, 32'h0000_BEEF);
    chk("t5.ready_back", 32'(e_ready_o), 32'd1);
    tick();
    e_valid_i = 1'b0;
    chk("t5.add_mvalid", 32'(m_valid_o), 32'd1);
    chk("t5.add_result", m_bus_o.result, 32'h0000_0055);
    tick();
    chk("t5.mv_drop", 32'(m_valid_o), 32'd0);

    // 6: reset while waiting for read data, then a late rvalid
    e_valid_i = 1'b1;
    e_bus_i   = mk(1, F3_LW, 32'h0000_5000, 32'd0);
    tick();
    e_valid_i  = 1'b0;
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("t6.rst_ready", 32'(e_ready_o), 32'd1);
    chk("t6.rst_req", 32'(dmem_req_o), 32'd0);
    chk("t6.rst_addr", dmem_addr_o, 32'd0);
    chk("t6.rst_result", m_bus_o.result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("t6.late_rv", 32'(m_valid_o), 32'd0);
    tick();
    chk("t6.late_rv2", 32'(m_valid_o), 32'd0);
    do_op("t6.after", mk(1, F3_LH, 32'h0000_6006, 32'd0), 1, 1, 32'h8001_7FFF);
    tick();

    // randomized mix of all instruction classes
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [2:0] f3;
      logic [31:0] ex;
      kind = $urandom_range(0, 2);
      f3   = (kind == 2) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 7)];
      ex   = $urandom;
      if ($urandom_range(0, 3) != 0) ex = ex & ~32'(acc_bytes(f3) - 1);
      do_op("rnd", mk(kind, f3, ex, $urandom), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom);
      tick();
      chk("rnd.mv_drop", 32'(m_valid_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
